ramb16_s1_arb: RTL
==================

Name: ramb16_s1_arb

Overview:
- Two-port round-robin arbiter and sequencer that shares one single-port 16K x 1 block RAM (RAMB16_S1-class primitive, WRITE_FIRST) between requesters A and B.
- Registers the winning request onto the RAM pins and routes the read data back to its owner.
- Optionally clears the whole RAM after reset, before granting any requester.
- Sits between client logic and the RAM primitive instance.

Parameters:
- ADDR_W, 14, RAM address width; fixed at 14 for the 16384 x 1 organisation.
- CLEAR_VAL, 1'b0, bit written to every location by the clear sequencer.

Ports:
- CLK  in  1  rising-edge clock, shared with the RAM.
- RST_N  in  1  asynchronous active-low reset.
- A_REQ  in  1  port A request; held with A_WE/A_ADDR/A_DI stable until A_GNT.
- A_WE  in  1  1 = write, 0 = read.
- A_ADDR  in  ADDR_W  port A address.
- A_DI  in  1  port A write data.
- A_GNT  out  1  one-cycle accept pulse, combinational in the accept cycle.
- A_RVALID  out  1  read data valid pulse.
- A_RDATA  out  1  read data; qualified by A_RVALID.
- B_REQ, B_WE, B_ADDR, B_DI, B_GNT, B_RVALID, B_RDATA  same as the A port, for requester B.
- RAM_EN  out  1  to RAM EN.
- RAM_WE  out  1  to RAM WE.
- RAM_ADDR  out  ADDR_W  to RAM ADDR.
- RAM_DI  out  1  to RAM DI.
- RAM_SSR  out  1  to RAM SSR; constant 0.
- RAM_DO  in  1  from RAM DO.
- READY  out  1  high once the arbiter accepts requests.

Behaviour:
- Reset (RST_N low, async):
  - A_GNT, B_GNT, A_RVALID, B_RVALID, RAM_EN, RAM_WE, RAM_SSR, READY = 0.
  - RAM_ADDR = 0, RAM_DI = 0, A_RDATA = B_RDATA = 0.
  - Priority pointer = A; clear counter = 0; read-tag pipeline emptied.
- FSM: INIT -> (CLEAR) -> RUN.
  - INIT lasts exactly one cycle after reset release.
  - RUN is terminal until the next reset.
  - READY = (state == RUN), registered.
- Arbitration in RUN (cycle t):
  - Only one REQ high: that port is granted.
  - Both high: the port named by the pointer is granted.
  - After any grant the pointer moves to the other port; with no grant the pointer holds.
  - At most one GNT per cycle; GNT is never asserted outside RUN.
- RAM drive (cycle t+1): the granted request is registered onto the RAM pins.
  - RAM_EN = 1, RAM_WE = WE, RAM_ADDR = ADDR, RAM_DI = DI.
  - Cycles with no grant: RAM_EN = 0, RAM_WE = 0; ADDR/DI hold their previous values.
- Read return (cycle t+2): for a granted read, owner x_RVALID = 1 and x_RDATA = RAM_DO.
  - A 2-stage {valid, owner} tag pipeline tracks ownership.
  - Writes never raise RVALID, even though a WRITE_FIRST RAM changes DO.
  - The non-owner's RDATA holds its last value.
- Throughput and ordering:
  - One access per cycle; back-to-back grants are allowed.
  - Alternating A/B under continuous contention.
  - Read latency from GNT is exactly 2 cycles; returns are in grant order.
- Same-address write then read (write at t, read at t+1): the read returns the new data. This follows from the RAM's sequential behaviour; no bypass logic.
- A requester dropping REQ before GNT is legal; no state is kept for it.
- Reset mid-operation: in-flight reads are discarded (no RVALID) and the FSM restarts at INIT.

Optional Feature:
- Macro: RAMB16_S1_ARB_CLEAR_EN.
- Defined:
  - INIT -> CLEAR. CLEAR issues 16384 writes, one per cycle: RAM_EN = 1, RAM_WE = 1, RAM_DI = CLEAR_VAL, RAM_ADDR = 0..16383 ascending from a 14-bit counter.
  - CLEAR -> RUN after the write to 16383 is presented; the counter wraps to 0.
  - READY first rises 16386 cycles after reset release.
  - No GNT during CLEAR; REQs are left pending.
  - Reset during CLEAR restarts the clear at address 0.
- Undefined: INIT -> RUN directly; READY rises on the second cycle after reset release; no clear counter is present.

Decomposition:
- Package ramb16_arb_pkg holds:
  - localparams RAM_DEPTH = 16384 and ADDR_W = 14;
  - typedef state_t enum {INIT, CLEAR, RUN};
  - typedef owner_t enum {OWN_A, OWN_B};
  - typedef struct rd_tag_t {valid, owner}.
- One sub-module, rr_arb2: 2-way round-robin grant logic plus pointer register, with async active-low reset.
- Datapath, FSM, clear counter and tag pipeline live in the top module.

Test Plan:
- Reset release (macro undefined), then A writes 1 to addr 0x0005 and later reads it -> A_GNT at accept; RAM_EN = RAM_WE = 1, RAM_ADDR = 0x0005 one cycle later; read gives A_RVALID = 1, A_RDATA = 1 two cycles after its GNT; B_RVALID stays 0.
- A and B both hold reads for 6 cycles (A addr 0x3FFF, B addr 0x0000) -> grants A,B,A,B,A,B; returns match the owners, one per cycle, each 2 cycles after its grant.
- B writes 0 to 0x1234 at t, A reads 0x1234 at t+1 (pointer already at A for the next tie) -> A_RDATA = 0 at t+3; no RVALID for the write.
- RAMB16_S1_ARB_CLEAR_EN defined, CLEAR_VAL = 1, A_REQ high from reset -> no A_GNT and READY = 0 for 16386 cycles; RAM_ADDR sweeps 0..16383 with RAM_WE = 1; READY = 1 the next cycle, then A_GNT, and reads of random addresses return 1.
- RST_N pulsed low while an A read is 1 cycle from return, and again mid-clear at address 0x0800 -> A_RVALID never asserts; clear restarts at 0x0000; all outputs show their reset values immediately.

Source files
------------

// File: rtl/ramb16_arb_pkg.sv
// Shared types for the RAMB16_S1 two-port arbiter: FSM states, read owner and read-return tag.
`default_nettype none

package ramb16_arb_pkg;
  localparam int RAM_DEPTH = 16384;
  localparam int ADDR_W    = 14;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;
endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic; the pointer names the port that wins a tie.
`default_nettype none

module rr_arb2
  import ramb16_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  owner_t ptr_q, ptr_d;

  assign gnt_a_o = en_i & req_a_i & (~req_b_i | (ptr_q == OWN_A));
  assign gnt_b_o = en_i & req_b_i & (~req_a_i | (ptr_q == OWN_B));

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_a_o)      ptr_d = OWN_B;
    else if (gnt_b_o) ptr_d = OWN_A;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ptr_q <= OWN_A;
    else          ptr_q <= ptr_d;
  end

endmodule

`default_nettype wire

// File: rtl/ramb16_s1_arb.sv
// Round-robin sharing of one 16K x 1 WRITE_FIRST block RAM between requesters A and B.
// Define RAMB16_S1_ARB_CLEAR_EN to fill the RAM with CLEAR_VAL after reset before granting.
`default_nettype none

module ramb16_s1_arb #(
  parameter int   ADDR_W    = 14,
  parameter logic CLEAR_VAL = 1'b0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              A_REQ,
  input  logic              A_WE,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic              A_DI,
  output logic              A_GNT,
  output logic              A_RVALID,
  output logic              A_RDATA,
  input  logic              B_REQ,
  input  logic              B_WE,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic              B_DI,
  output logic              B_GNT,
  output logic              B_RVALID,
  output logic              B_RDATA,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_DI,
  output logic              RAM_SSR,
  input  logic              RAM_DO,
  output logic              READY
);
  import ramb16_arb_pkg::*;

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_di_q, ram_di_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  rd_tag_t           tag0_q, tag0_d, tag1_q;
  logic              a_rdata_q, b_rdata_q;
  logic              clr_done;

`ifdef RAMB16_S1_ARB_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                 clr_cnt_q <= '0;
    else if (state_q == CLEAR)  clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
  end

  assign clr_done = (clr_cnt_q == ADDR_W'(RAM_DEPTH - 1));
`else
  logic unused_clear_val;
  assign unused_clear_val = CLEAR_VAL;
  assign clr_done         = 1'b1;
`endif

  // Grants only open once READY is visible, so no grant can precede READY.
  rr_arb2 u_arb (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .en_i    (ready_q),
    .req_a_i (A_REQ),
    .req_b_i (B_REQ),
    .gnt_a_o (A_GNT),
    .gnt_b_o (B_GNT)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef RAMB16_S1_ARB_CLEAR_EN
      INIT:    state_d = CLEAR;
`else
      INIT:    state_d = RUN;
`endif
      CLEAR:   if (clr_done) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    ready_d      = (state_q == RUN);
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_di_d     = ram_di_q;
    tag0_d.valid = 1'b0;
    tag0_d.owner = OWN_A;
`ifdef RAMB16_S1_ARB_CLEAR_EN
    if (state_q == CLEAR) begin
      ram_en_d   = 1'b1;
      ram_we_d   = 1'b1;
      ram_addr_d = clr_cnt_q;
      ram_di_d   = CLEAR_VAL;
    end else
`endif
    if (A_GNT) begin
      ram_en_d     = 1'b1;
      ram_we_d     = A_WE;
      ram_addr_d   = A_ADDR;
      ram_di_d     = A_DI;
      tag0_d.valid = ~A_WE;
      tag0_d.owner = OWN_A;
    end else if (B_GNT) begin
      ram_en_d     = 1'b1;
      ram_we_d     = B_WE;
      ram_addr_d   = B_ADDR;
      ram_di_d     = B_DI;
      tag0_d.valid = ~B_WE;
      tag0_d.owner = OWN_B;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ready_q    <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_di_q   <= 1'b0;
      tag0_q     <= '0;
      tag1_q     <= '0;
      a_rdata_q  <= 1'b0;
      b_rdata_q  <= 1'b0;
    end else begin
      ready_q    <= ready_d;
      ram_en_q   <= ram_en_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_di_q   <= ram_di_d;
      tag0_q     <= tag0_d;
      tag1_q     <= tag0_q;
      a_rdata_q  <= A_RDATA;
      b_rdata_q  <= B_RDATA;
    end
  end

  // RAM_DO is valid the cycle after the RAM samples its pins, i.e. when the tag reaches stage 1.
  assign A_RVALID = tag1_q.valid & (tag1_q.owner == OWN_A);
  assign B_RVALID = tag1_q.valid & (tag1_q.owner == OWN_B);
  assign A_RDATA  = A_RVALID ? RAM_DO : a_rdata_q;
  assign B_RDATA  = B_RVALID ? RAM_DO : b_rdata_q;

  assign RAM_EN   = ram_en_q;
  assign RAM_WE   = ram_we_q;
  assign RAM_ADDR = ram_addr_q;
  assign RAM_DI   = ram_di_q;
  assign RAM_SSR  = 1'b0;
  assign READY    = ready_q;

endmodule

`default_nettype wire
